// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, flag bit positions
// and the ALU control codes the sequencer forwards untouched.
package alu_pkg;

  typedef enum logic [1:0] {
    LIBRE     = 2'd0,
    EJECUTA   = 2'd1,
    RESPUESTA = 2'd2
  } estado_t;

  // Positions inside the {carry, overflow, zero, negative} flag vector
  localparam int FLAG_CARRY    = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 0;

  localparam logic [2:0] ALU_SUMA  = 3'd0;
  localparam logic [2:0] ALU_RESTA = 3'd1;

endpackage

// File: rtl/arbitro_2.sv
// Two-way request arbiter. Round-robin when SECUENCIADOR_RR_EN is defined,
// otherwise fixed priority with requester 0 winning every tie.
module arbitro_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

`ifdef SECUENCIADOR_RR_EN
  logic last_q;  // index of the requester granted most recently

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept_i) begin
      last_q <= grant_o[1];
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through it can leave a value held and infer a latch.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, accept_i};
  assign grant_o   = {req_i[1] & ~req_i[0], req_i[0]};
`endif

endmodule

// File: rtl/secuenciador_alu.sv
// Sequences two requesters onto one shared combinational ALU, one operation
// at a time. Arbitration policy is selected by SECUENCIADOR_RR_EN.
module secuenciador_alu
  import alu_pkg::*;
#(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [ANCHO-1:0] req0_a,
  input  logic [ANCHO-1:0] req0_b,
  input  logic [2:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [ANCHO-1:0] req1_a,
  input  logic [ANCHO-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             req1_ready,
  output logic [ANCHO-1:0] alu_a,
  output logic [ANCHO-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [ANCHO-1:0] alu_resultado,
  input  logic [3:0]       alu_flags,
  output logic             res_valid,
  output logic             res_id,
  output logic [ANCHO-1:0] res_data,
  output logic [3:0]       res_flags,
  input  logic             res_ready
);

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             id_q;
  logic             res_valid_q, res_id_q;
  logic [ANCHO-1:0] res_data_q;
  logic [3:0]       res_flags_q;
  logic [1:0]       grant;
  logic             acepta;

  arbitro_2 u_arbitro (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({req1_valid, req0_valid}),
    .accept_i (acepta),
    .grant_o  (grant)
  );

  // Ready is only offered in LIBRE and out of reset, so the grant never leaks
  // into a busy cycle.
  always_comb begin
    estado_d   = estado_q;
    acepta     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (estado_q)
      LIBRE: begin
        if (!rst) begin
          req0_ready = grant[0];
          req1_ready = grant[1];
          if (|grant) begin
            acepta   = 1'b1;
            estado_d = EJECUTA;
          end
        end
      end
      EJECUTA:   estado_d = RESPUESTA;
      RESPUESTA: if (res_ready) estado_d = LIBRE;
      default:   estado_d = LIBRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= LIBRE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      estado_q <= estado_d;
      if (acepta) begin
        a_q  <= grant[1] ? req1_a  : req0_a;
        b_q  <= grant[1] ? req1_b  : req0_b;
        op_q <= grant[1] ? req1_op : req0_op;
        id_q <= grant[1];
      end
      if (estado_q == EJECUTA) begin
        res_valid_q <= 1'b1;
        res_data_q  <= alu_resultado;
        res_flags_q <= alu_flags;
        res_id_q    <= id_q;
      end else if (estado_q == RESPUESTA && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = op_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;

endmodule
